// File: rtl/word_serializer.sv
// Word serializer: a small word FIFO feeding a shift register that emits OUT_W-bit beats.
// Optional synchronous flush input enabled by defining WORD_SERIALIZER_FLUSH_EN.
module word_serializer #(
   parameter int IN_W      = 32,
   parameter int OUT_W     = 4,
   parameter int DEPTH     = 2,
   parameter int MSB_FIRST = 0
) (
   input  logic                           clk,
   input  logic                           rst,
`ifdef WORD_SERIALIZER_FLUSH_EN
   input  logic                           flush,
`endif
   input  logic [IN_W-1:0]                in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [OUT_W-1:0]               out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_last,
   output logic [$clog2(DEPTH+1)-1:0]     level
);

   localparam int BEATS  = IN_W / OUT_W;
   localparam int BEAT_W = $clog2(BEATS);
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LVL_W  = $clog2(DEPTH + 1);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [IN_W-1:0]   shreg_q, shreg_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic [IN_W-1:0]   mem_q [DEPTH];
   logic [IN_W-1:0]   mem_d [DEPTH];
   logic              push;
   logic              pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      beat_d   = beat_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      mem_d    = mem_q;
      push     = in_valid && in_ready;
      pop      = 1'b0;

      case (state_q)
         IDLE: begin
            if (level_q != '0) begin
               pop     = 1'b1;
               state_d = SEND;
               shreg_d = mem_q[rd_ptr_q];
               beat_d  = '0;
            end
         end
         SEND: begin
            if (out_ready) begin
               // Reloading on the last beat keeps back-to-back words bubble-free
               if (beat_q == LAST_BEAT) begin
                  beat_d = '0;
                  if (level_q != '0) begin
                     pop     = 1'b1;
                     shreg_d = mem_q[rd_ptr_q];
                  end else begin
                     state_d = IDLE;
                     shreg_d = '0;
                  end
               end else begin
                  beat_d  = beat_q + 1'b1;
                  shreg_d = (MSB_FIRST != 0) ? (shreg_q << OUT_W) : (shreg_q >> OUT_W);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (push) begin
         mem_d[wr_ptr_q] = in_data;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;

`ifdef WORD_SERIALIZER_FLUSH_EN
      if (flush) begin
         state_d  = IDLE;
         shreg_d  = '0;
         beat_d   = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         mem_d    = mem_q;
      end
`endif

      out_valid_d = (state_d == SEND);
      out_last_d  = (state_d == SEND) && (beat_d == LAST_BEAT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         beat_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         beat_q      <= beat_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   // Storage needs no reset: the pointers and level decide what is valid
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign in_ready  = (level_q != LVL_W'(DEPTH));
   assign level     = level_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = (MSB_FIRST != 0) ? shreg_q[IN_W-1 -: OUT_W] : shreg_q[OUT_W-1:0];

endmodule

// File: tb/tb_word_serializer.sv
// Directed self-checking bench for word_serializer: an LSB-first and an MSB-first
// instance share one stimulus stream.
module tb_word_serializer;

   logic        clk;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic        out_ready;

   logic        in_ready, out_valid, out_last;
   logic [3:0]  out_data;
   logic [1:0]  level;

   logic        m_in_ready, m_out_valid, m_out_last;
   logic [3:0]  m_out_data;
   logic [1:0]  m_level;

   int n_checks = 0;
   int n_fails  = 0;

   word_serializer #(.IN_W(32), .OUT_W(4), .DEPTH(2), .MSB_FIRST(0)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .level(level)
   );

   word_serializer #(.IN_W(32), .OUT_W(4), .DEPTH(2), .MSB_FIRST(1)) dut_msb (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(m_in_ready),
      .out_data(m_out_data), .out_valid(m_out_valid), .out_ready(out_ready),
      .out_last(m_out_last), .level(m_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle before driving or sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] nib(input logic [31:0] w, input int i);
      return 4'((w >> (4 * i)) & 32'hF);
   endfunction

   task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic r);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
   endtask

   logic [31:0] words [3];

   initial begin
      rst = 1'b1;
      apply_stimulus(1'b0, 32'h0, 1'b0);
      tick();
      tick();
      check_output("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check_output("rst_out_data", {28'b0, out_data}, 32'd0);
      check_output("rst_out_last", {31'b0, out_last}, 32'd0);
      check_output("rst_level", {30'b0, level}, 32'd0);
      check_output("rst_in_ready", {31'b0, in_ready}, 32'd1);
      rst = 1'b0;
      tick();

      // Single word, LSB-first and MSB-first, out_ready held high
      apply_stimulus(1'b1, 32'h87654321, 1'b1);
      tick();
      check_output("lat_level", {30'b0, level}, 32'd1);
      check_output("lat_no_valid", {31'b0, out_valid}, 32'd0);
      apply_stimulus(1'b0, 32'h0, 1'b1);
      tick();
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) tick();
         check_output("seq_valid", {31'b0, out_valid}, 32'd1);
         check_output("seq_data", {28'b0, out_data}, 32'(k));
         check_output("seq_last", {31'b0, out_last}, (k == 8) ? 32'd1 : 32'd0);
         check_output("msb_data", {28'b0, m_out_data}, 32'(9 - k));
         check_output("msb_last", {31'b0, m_out_last}, (k == 8) ? 32'd1 : 32'd0);
      end
      tick();
      check_output("seq_idle_valid", {31'b0, out_valid}, 32'd0);
      check_output("seq_idle_data", {28'b0, out_data}, 32'd0);

      // Fill the FIFO with the sink stalled
      words[0] = 32'h11111111;
      words[1] = 32'h22222222;
      words[2] = 32'h33333333;
      apply_stimulus(1'b1, words[0], 1'b0);
      tick();
      apply_stimulus(1'b1, words[1], 1'b0);
      tick();
      check_output("fill_level1", {30'b0, level}, 32'd1);
      check_output("fill_in_ready1", {31'b0, in_ready}, 32'd1);
      check_output("fill_first_beat", {28'b0, out_data}, 32'd1);
      apply_stimulus(1'b1, words[2], 1'b0);
      tick();
      check_output("full_level", {30'b0, level}, 32'd2);
      check_output("full_in_ready", {31'b0, in_ready}, 32'd0);
      apply_stimulus(1'b1, 32'hDEADBEEF, 1'b0);
      tick();
      tick();
      check_output("full_level_held", {30'b0, level}, 32'd2);
      check_output("stall_data_held", {28'b0, out_data}, 32'd1);
      check_output("stall_valid_held", {31'b0, out_valid}, 32'd1);
      apply_stimulus(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 24; i++) begin
         check_output("drain_valid", {31'b0, out_valid}, 32'd1);
         check_output("drain_data", {28'b0, out_data}, {28'b0, nib(words[i / 8], i % 8)});
         check_output("drain_last", {31'b0, out_last}, (i % 8 == 7) ? 32'd1 : 32'd0);
         tick();
      end
      check_output("drain_idle", {31'b0, out_valid}, 32'd0);
      check_output("drain_level", {30'b0, level}, 32'd0);

      // Two words back to back with no bubble
      words[0] = 32'hAAAAAAAA;
      words[1] = 32'h55555555;
      apply_stimulus(1'b1, words[0], 1'b1);
      tick();
      apply_stimulus(1'b1, words[1], 1'b1);
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         check_output("b2b_valid", {31'b0, out_valid}, 32'd1);
         check_output("b2b_data", {28'b0, out_data}, {28'b0, nib(words[i / 8], i % 8)});
         check_output("b2b_last", {31'b0, out_last}, (i % 8 == 7) ? 32'd1 : 32'd0);
         tick();
      end
      check_output("b2b_idle", {31'b0, out_valid}, 32'd0);

      // Alternating stall: each beat must appear once held, once consumed
      apply_stimulus(1'b1, 32'h87654321, 1'b0);
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b0);
      tick();
      begin
         int e;
         e = 1;
         for (int c = 0; c < 16; c++) begin
            out_ready = (c % 2 == 1);
            check_output("toggle_valid", {31'b0, out_valid}, 32'd1);
            check_output("toggle_data", {28'b0, out_data}, 32'(e));
            check_output("toggle_last", {31'b0, out_last}, (e == 8) ? 32'd1 : 32'd0);
            tick();
            if (c % 2 == 1) e++;
         end
      end
      check_output("toggle_idle", {31'b0, out_valid}, 32'd0);

      // Reset mid-word with a second word queued
      apply_stimulus(1'b1, 32'h87654321, 1'b1);
      tick();
      apply_stimulus(1'b1, 32'hCAFEF00D, 1'b1);
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b1);
      tick();
      tick();
      check_output("mid_beat3", {28'b0, out_data}, 32'd3);
      check_output("mid_level", {30'b0, level}, 32'd1);
      rst = 1'b1;
      tick();
      check_output("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      check_output("mid_rst_level", {30'b0, level}, 32'd0);
      check_output("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
      check_output("mid_rst_data", {28'b0, out_data}, 32'd0);
      rst = 1'b0;
      apply_stimulus(1'b1, 32'h0FEDCBA9, 1'b1);
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b1);
      tick();
      for (int i = 0; i < 8; i++) begin
         check_output("post_rst_valid", {31'b0, out_valid}, 32'd1);
         check_output("post_rst_data", {28'b0, out_data}, {28'b0, nib(32'h0FEDCBA9, i)});
         check_output("post_rst_last", {31'b0, out_last}, (i == 7) ? 32'd1 : 32'd0);
         tick();
      end
      check_output("post_rst_idle", {31'b0, out_valid}, 32'd0);
      check_output("post_rst_level", {30'b0, level}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
